// File: rtl/r_tile_arbiter_if.sv
// Bundle of the requester-side handshake and the bank-side port of one
// register bank tile. The arbiter takes the slave view; whoever drives the
// requests and models the bank takes the master view.
interface r_tile_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
);
    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_is_write;
    logic [NUM_REQ*7-1:0]      req_reg_id;
    logic [NUM_REQ*5-1:0]      req_queue_id;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_rdata;
    logic [1:0]                resp_code;

    // Bank side
    logic                      bank_read_req;
    logic                      bank_write_req;
    logic [6:0]                bank_reg_id;
    logic [4:0]                bank_queue_id;
    logic [DATA_W-1:0]         bank_write_data;
    logic [DATA_W-1:0]         bank_read_data;
    logic                      bank_ack;
    logic                      bank_alignment_err;

    modport slave (
        input  req_valid, req_is_write, req_reg_id, req_queue_id, req_wdata,
        input  bank_read_data, bank_ack, bank_alignment_err,
        output req_ready, resp_valid, resp_rdata, resp_code,
        output bank_read_req, bank_write_req, bank_reg_id, bank_queue_id,
        output bank_write_data
    );

    modport master (
        output req_valid, req_is_write, req_reg_id, req_queue_id, req_wdata,
        output bank_read_data, bank_ack, bank_alignment_err,
        input  req_ready, resp_valid, resp_rdata, resp_code,
        input  bank_read_req, bank_write_req, bank_reg_id, bank_queue_id,
        input  bank_write_data
    );
endinterface

// File: rtl/r_tile_arbiter.sv
// Round-robin arbiter and access sequencer for one register bank tile.
// Each grant turns into one single-cycle bank strobe, a bounded wait for
// the bank's ack, and a one-cycle registered response to the winner.
// Requests aimed at another bank are answered locally without touching
// the bank.
module r_tile_arbiter #(
    parameter int BANK_ID = 0,
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    r_tile_arbiter_if.slave    bus,
    output logic [7:0]         err_count
);

    localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0]         BANK_SEL = 2'(BANK_ID);
    localparam logic [7:0]         TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_ALIGN   = 2'd1;
    localparam logic [1:0] CODE_BANK    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic                r_is_write;
    logic [6:0]          r_reg_id;
    logic [4:0]          r_queue_id;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err_lat;
    logic [7:0]          r_tmo_cnt;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [1:0]          r_resp_code;
    logic [7:0]          r_err_count;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W:0]      w_probe;
    logic                w_sel_is_write;
    logic [6:0]          w_sel_reg_id;
    logic [4:0]          w_sel_queue_id;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_wrong_bank;
    logic                w_accept;
    logic                w_ack_done;
    logic                w_timeout;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_probe  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_probe = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_probe >= (IDX_W+1)'(NUM_REQ)) begin
                w_probe = w_probe - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && bus.req_valid[w_probe[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_probe[IDX_W-1:0];
            end
        end
    end

    // Mux out the winner's request fields from the flattened buses.
    always_comb begin
        w_sel_is_write = 1'b0;
        w_sel_reg_id   = '0;
        w_sel_queue_id = '0;
        w_sel_wdata    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_is_write = bus.req_is_write[i];
                w_sel_reg_id   = bus.req_reg_id[i*7 +: 7];
                w_sel_queue_id = bus.req_queue_id[i*5 +: 5];
                w_sel_wdata    = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
        w_sel_wrong_bank = (w_sel_reg_id[1:0] != BANK_SEL);
    end

    // FSM state register; reset aborts whatever access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the control strobes the datapath acts on.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_next_state = w_sel_wrong_bank ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (bus.bank_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = RESP;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request latch, error/timeout tracking, response and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_idx        <= '0;
            r_is_write   <= 1'b0;
            r_reg_id     <= '0;
            r_queue_id   <= '0;
            r_wdata      <= '0;
            r_err_lat    <= 1'b0;
            r_tmo_cnt    <= '0;
            r_resp_rdata <= '0;
            r_resp_code  <= CODE_OK;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx      <= w_winner;
                        r_is_write <= w_sel_is_write;
                        r_reg_id   <= w_sel_reg_id;
                        r_queue_id <= w_sel_queue_id;
                        r_wdata    <= w_sel_wdata;
                        if (w_sel_wrong_bank) begin
                            r_resp_code  <= CODE_BANK;
                            r_resp_rdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_err_lat <= bus.bank_alignment_err;
                    r_tmo_cnt <= '0;
                end
                WAIT: begin
                    if (w_ack_done) begin
                        if (r_err_lat) begin
                            r_resp_code  <= CODE_ALIGN;
                            r_resp_rdata <= '0;
                        end else begin
                            r_resp_code  <= CODE_OK;
                            r_resp_rdata <= r_is_write ? '0 : bus.bank_read_data;
                        end
                    end else if (w_timeout) begin
                        r_resp_code  <= CODE_TIMEOUT;
                        r_resp_rdata <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                    if (r_resp_code != CODE_OK && r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: grant only from IDLE, strobes only in ISSUE, response pulse in RESP.
    always_comb begin
        bus.req_ready       = (r_state == IDLE && w_found) ? (ONE_HOT0 << w_winner) : '0;
        bus.resp_valid      = (r_state == RESP) ? (ONE_HOT0 << r_idx) : '0;
        bus.resp_rdata      = r_resp_rdata;
        bus.resp_code       = r_resp_code;
        bus.bank_read_req   = (r_state == ISSUE) && !r_is_write;
        bus.bank_write_req  = (r_state == ISSUE) && r_is_write;
        bus.bank_reg_id     = r_reg_id;
        bus.bank_queue_id   = r_queue_id;
        bus.bank_write_data = r_wdata;
        err_count           = r_err_count;
    end

endmodule

// File: tb/tb_r_tile_arbiter.sv
// Scoreboard bench for r_tile_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares them against the DUT.
module tb_r_tile_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int BANK_ID = 1;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_count;

    r_tile_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    r_tile_arbiter #(
        .BANK_ID(BANK_ID),
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        wr;
        logic [6:0]  regId;
        logic [4:0]  qid;
        logic [63:0] wdata;
        bit          strobe;
        int          gap;
        logic [1:0]  code;
        logic [63:0] rdata;
        int          latency;
    } txn_t;

    txn_t        expQ[$];
    txn_t        cur;
    bit          curValid      = 1'b0;
    bit          curStrobeSeen = 1'b0;
    int          curGrantCycle = 0;
    int          lastGrantCycle = -100;
    int          grantCount = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          alignMode = 1'b0;
    bit          noAck = 1'b0;
    logic [63:0] regs [32];

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: registered ack and read data one cycle after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bank_ack       <= 1'b0;
            bus.bank_read_data <= '0;
            for (int k = 0; k < 32; k++) regs[k] <= 64'h1000_0000_0000_0000 + 64'(k);
            regs[2] <= 64'h0000_0000_DEAD_BEEF;
        end else begin
            bus.bank_ack <= (bus.bank_read_req || bus.bank_write_req) && !noAck;
            if (bus.bank_read_req)  bus.bank_read_data <= regs[bus.bank_reg_id[6:2]];
            if (bus.bank_write_req) regs[bus.bank_reg_id[6:2]] <= bus.bank_write_data;
        end
    end

    assign bus.bank_alignment_err = alignMode && (bus.bank_read_req || bus.bank_write_req);

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] one;
        one = NUM_REQ'(1);
        return one << i;
    endfunction

    function automatic txn_t mkTxn(input int idx, input logic wr, input logic [6:0] regId,
                                   input logic [4:0] qid, input logic [63:0] wdata,
                                   input logic [1:0] code, input logic [63:0] rdata,
                                   input int latency, input bit strobe, input int gap);
        txn_t t;
        t.idx = idx; t.wr = wr; t.regId = regId; t.qid = qid; t.wdata = wdata;
        t.code = code; t.rdata = rdata; t.latency = latency; t.strobe = strobe; t.gap = gap;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: grants, bank strobes and responses are compared as they appear.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_ready != '0) begin
                grantCount++;
                if (expQ.size() == 0) begin
                    failNote("unexpected grant");
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("grant one-hot", 64'(bus.req_ready), 64'(onehot(cur.idx)));
                    if (cur.gap >= 0) checkOutput("grant spacing", 64'(cyc - lastGrantCycle), 64'(cur.gap));
                    curValid      = 1'b1;
                    curGrantCycle = cyc;
                    curStrobeSeen = 1'b0;
                end
                lastGrantCycle = cyc;
            end
            if (bus.bank_read_req || bus.bank_write_req) begin
                if (!curValid || !cur.strobe) begin
                    failNote("unexpected bank strobe");
                end else begin
                    checkOutput("strobe cycle", 64'(cyc - curGrantCycle), 64'd1);
                    checkOutput("strobe read", 64'(bus.bank_read_req), 64'(!cur.wr));
                    checkOutput("strobe write", 64'(bus.bank_write_req), 64'(cur.wr));
                    checkOutput("bank reg id", 64'(bus.bank_reg_id), 64'(cur.regId));
                    checkOutput("bank queue id", 64'(bus.bank_queue_id), 64'(cur.qid));
                    if (cur.wr) checkOutput("bank write data", bus.bank_write_data, cur.wdata);
                    curStrobeSeen = 1'b1;
                end
            end
            if (bus.resp_valid != '0) begin
                if (!curValid) begin
                    failNote("unexpected response");
                end else begin
                    checkOutput("resp one-hot", 64'(bus.resp_valid), 64'(onehot(cur.idx)));
                    checkOutput("resp code", 64'(bus.resp_code), 64'(cur.code));
                    checkOutput("resp rdata", bus.resp_rdata, cur.rdata);
                    checkOutput("resp latency", 64'(cyc - curGrantCycle), 64'(cur.latency));
                    checkOutput("strobe issued", 64'(curStrobeSeen), 64'(cur.strobe));
                    curValid = 1'b0;
                end
            end
        end
    end

    // One request from one requester: push expectation, hold valid until granted.
    task automatic applyStimulus(input int idx, input logic wr, input logic [6:0] regId,
                                 input logic [4:0] qid, input logic [63:0] wdata,
                                 input logic [1:0] code, input logic [63:0] rdata,
                                 input int latency, input bit strobe);
        bit got;
        expQ.push_back(mkTxn(idx, wr, regId, qid, wdata, code, rdata, latency, strobe, -1));
        bus.req_is_write[idx]              = wr;
        bus.req_reg_id[idx*7 +: 7]         = regId;
        bus.req_queue_id[idx*5 +: 5]       = qid;
        bus.req_wdata[idx*DATA_W +: DATA_W] = wdata;
        bus.req_valid[idx]                 = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) got = 1'b1;
        end
        if (!got) failNote("grant wait timeout");
        @(posedge clk);
        #1;
        bus.req_valid[idx] = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            if (expQ.size() == 0 && !curValid) done = 1'b1;
        end
        if (!done) failNote("drain timeout");
        #1;
    endtask

    task automatic waitGrants(input int target);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            if (grantCount >= target) done = 1'b1;
        end
        if (!done) failNote("round-robin grant timeout");
        #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int base;
        bus.req_valid    = '0;
        bus.req_is_write = '0;
        bus.req_reg_id   = '0;
        bus.req_queue_id = '0;
        bus.req_wdata    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("reset strobes", 64'({bus.bank_read_req, bus.bank_write_req}), 64'd0);
        checkOutput("reset resp_code", 64'(bus.resp_code), 64'd0);
        checkOutput("reset err_count", 64'(err_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single read of reg 9 (bank 1, row 2)
        applyStimulus(0, 1'b0, 7'd9, 5'd1, 64'd0, 2'd0, 64'h0000_0000_DEAD_BEEF, 3, 1'b1);
        waitDrain();
        // Write reg 13, then read it back from another requester
        applyStimulus(1, 1'b1, 7'd13, 5'd2, 64'h0000_0000_CAFE_F00D, 2'd0, 64'd0, 3, 1'b1);
        waitDrain();
        applyStimulus(3, 1'b0, 7'd13, 5'd3, 64'd0, 2'd0, 64'h0000_0000_CAFE_F00D, 3, 1'b1);
        waitDrain();

        // Round-robin with all four requesting (rr_ptr is back at 0)
        base = grantCount;
        expQ.push_back(mkTxn(0, 1'b0, 7'd5,  5'd0, 64'd0, 2'd0, 64'h1000_0000_0000_0001, 3, 1'b1, -1));
        expQ.push_back(mkTxn(1, 1'b0, 7'd9,  5'd1, 64'd0, 2'd0, 64'h0000_0000_DEAD_BEEF, 3, 1'b1, 4));
        expQ.push_back(mkTxn(2, 1'b0, 7'd13, 5'd2, 64'd0, 2'd0, 64'h0000_0000_CAFE_F00D, 3, 1'b1, 4));
        expQ.push_back(mkTxn(3, 1'b0, 7'd17, 5'd3, 64'd0, 2'd0, 64'h1000_0000_0000_0004, 3, 1'b1, 4));
        expQ.push_back(mkTxn(0, 1'b0, 7'd5,  5'd0, 64'd0, 2'd0, 64'h1000_0000_0000_0001, 3, 1'b1, 4));
        expQ.push_back(mkTxn(2, 1'b0, 7'd13, 5'd2, 64'd0, 2'd0, 64'h0000_0000_CAFE_F00D, 3, 1'b1, 4));
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_is_write[i]    = 1'b0;
            bus.req_reg_id[i*7 +: 7]   = 7'(4*(i+1) + 1);
            bus.req_queue_id[i*5 +: 5] = 5'(i);
        end
        bus.req_valid = 4'b1111;
        waitGrants(base + 5);
        bus.req_valid = 4'b0100;
        waitGrants(base + 6);
        bus.req_valid = 4'b0000;
        waitDrain();
        checkOutput("err_count after OK traffic", 64'(err_count), 64'd0);

        // Wrong bank: reg 4 lives in bank 0
        applyStimulus(3, 1'b1, 7'd4, 5'd7, 64'h1234, 2'd2, 64'd0, 1, 1'b0);
        waitDrain();
        checkOutput("err_count after wrong bank", 64'(err_count), 64'd1);

        // Alignment error flagged during ISSUE
        alignMode = 1'b1;
        applyStimulus(0, 1'b0, 7'd9, 5'd1, 64'd0, 2'd1, 64'd0, 3, 1'b1);
        waitDrain();
        alignMode = 1'b0;
        checkOutput("err_count after alignment", 64'(err_count), 64'd2);

        // Timeout: bank never acks, response at grant+2+TIMEOUT
        noAck = 1'b1;
        applyStimulus(1, 1'b0, 7'd9, 5'd4, 64'd0, 2'd3, 64'd0, 2 + TIMEOUT, 1'b1);
        waitDrain();
        noAck = 1'b0;
        checkOutput("err_count after timeout", 64'(err_count), 64'd3);
        applyStimulus(2, 1'b0, 7'd5, 5'd5, 64'd0, 2'd0, 64'h1000_0000_0000_0001, 3, 1'b1);
        waitDrain();
        checkOutput("err_count after recovery", 64'(err_count), 64'd3);

        // Reset while waiting on the bank: no response, outputs cleared at once
        noAck = 1'b1;
        applyStimulus(0, 1'b0, 7'd9, 5'd6, 64'd0, 2'd0, 64'd0, 3, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid-op reset resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("mid-op reset strobes", 64'({bus.bank_read_req, bus.bank_write_req}), 64'd0);
        checkOutput("mid-op reset bank_reg_id", 64'(bus.bank_reg_id), 64'd0);
        checkOutput("mid-op reset bank_queue_id", 64'(bus.bank_queue_id), 64'd0);
        checkOutput("mid-op reset resp_rdata", bus.resp_rdata, 64'd0);
        checkOutput("mid-op reset resp_code", 64'(bus.resp_code), 64'd0);
        checkOutput("mid-op reset err_count", 64'(err_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        expQ.delete();
        curValid = 1'b0;
        noAck = 1'b0;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("err_count after reset", 64'(err_count), 64'd0);

        // Saturation: 300 wrong-bank requests
        for (int i = 0; i < 300; i++) begin
            applyStimulus(i % NUM_REQ, 1'b0, 7'd6, 5'(i % 32), 64'd0, 2'd2, 64'd0, 1, 1'b0);
            if (i == 99) begin
                waitDrain();
                checkOutput("err_count at 100", 64'(err_count), 64'd100);
            end
        end
        waitDrain();
        checkOutput("err_count saturated", 64'(err_count), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
